// File: rtl/fma16_pkg.sv
// fma16 shared definitions: format constants, flag layout and canonical NaN.
// Imported by the result queue and its storage FIFO.
package fma16_pkg;

    localparam int FLEN = 16;
    localparam int NE   = 5;
    localparam int NF   = 10;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    localparam int NFLAGS = 5;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fma_flags_t;

    localparam logic [FLEN-1:0] CANON_NAN = 16'h7E00;

endpackage

// File: rtl/fma16_sync_fifo.sv
// Generic synchronous FIFO with valid/ready ends and an occupancy count.
// Full/empty come from the count so pointers can wrap freely.
module fma16_sync_fifo #(
    parameter int WIDTH = 21,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             push;
    logic             pop;

    // Ready depends only on stored occupancy, never on the consumer side.
    assign push_ready = (count != CW'(DEPTH));
    assign pop_valid  = (count != '0);
    assign push       = push_valid & push_ready;
    assign pop        = pop_valid & pop_ready;
    assign pop_data   = mem[rptr];

    // Storage write; contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_count_max: assert property (@(posedge clk) disable iff (reset)
        count <= CW'(DEPTH));
`endif

endmodule

// File: rtl/fma16_result_queue.sv
// fma16 output stage: queues results with their exception flags and
// keeps the sticky accrued fflags register with a software clear.
module fma16_result_queue
    import fma16_pkg::*;
#(
    parameter int FLEN  = fma16_pkg::FLEN,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [FLEN-1:0] in_result,
    input  logic            in_invalid,
    input  logic            in_overflow,
    input  logic            in_underflow,
    input  logic            in_inexact,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FLEN-1:0] out_result,
    output logic [4:0]      out_flags,
    output logic [4:0]      fflags,
    input  logic            fflags_clr,
    output logic [CW-1:0]   count
);

    localparam int W = FLEN + NFLAGS;

    fma_flags_t   in_flags;
    logic [W-1:0] head;
    logic         push;

    // DZ is always zero: fused multiply-add never divides.
    assign in_flags = '{
        nv: in_invalid,
        dz: 1'b0,
        of: in_overflow,
        uf: in_underflow,
        nx: in_inexact
    };

    assign push = in_valid & in_ready;

    fma16_sync_fifo #(
        .WIDTH (W),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_valid (in_valid),
        .push_ready (in_ready),
        .push_data  ({in_result, in_flags}),
        .pop_valid  (out_valid),
        .pop_ready  (out_ready),
        .pop_data   (head),
        .count      (count)
    );

    assign out_result = head[W-1:NFLAGS];
    assign out_flags  = head[NFLAGS-1:0];

    // Sticky flags accrue on acceptance; new flags survive a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            fflags <= '0;
        end else begin
            fflags <= (fflags & ~{5{fflags_clr}})
                    | (push ? in_flags : 5'b0);
        end
    end

`ifndef SYNTHESIS
    a_in_stable: assert property (@(posedge clk) disable iff (reset)
        (in_valid && !in_ready) |=>
            ($stable(in_result) && $stable(in_invalid) &&
             $stable(in_overflow) && $stable(in_underflow) &&
             $stable(in_inexact)));
`endif

endmodule

// File: tb/tb_fma16_result_queue.sv
// Directed bench for fma16_result_queue with hand-computed expectations.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_fma16_result_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_result;
    logic        in_invalid;
    logic        in_overflow;
    logic        in_underflow;
    logic        in_inexact;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [4:0]  out_flags;
    logic [4:0]  fflags;
    logic        fflags_clr;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    fma16_result_queue #(.FLEN(16), .DEPTH(4), .CW(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_invalid   (in_invalid),
        .in_overflow  (in_overflow),
        .in_underflow (in_underflow),
        .in_inexact   (in_inexact),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_flags    (out_flags),
        .fflags       (fflags),
        .fflags_clr   (fflags_clr),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one input entry; flags given as {NV,OF,UF,NX}.
    task automatic drive(input logic v, input logic [15:0] r,
                         input logic [3:0] f);
        in_valid     = v;
        in_result    = r;
        in_invalid   = f[3];
        in_overflow  = f[2];
        in_underflow = f[1];
        in_inexact   = f[0];
    endtask

    initial begin
        reset      = 1'b1;
        out_ready  = 1'b0;
        fflags_clr = 1'b0;
        drive(1'b0, 16'h0000, 4'b0000);
        step();
        step();
        reset = 1'b0;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_fflags", 32'(fflags), 32'd0);

        // 1: single push, visible next cycle
        drive(1'b1, 16'h3C00, 4'b0001);
        step();
        drive(1'b0, 16'h3C00, 4'b0001);
        chk("t1_out_valid", 32'(out_valid), 32'd1);
        chk("t1_out_result", 32'(out_result), 32'h3C00);
        chk("t1_out_flags", 32'(out_flags), 32'b00001);
        chk("t1_fflags", 32'(fflags), 32'b00001);
        chk("t1_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t1_pop_count", 32'(count), 32'd0);
        chk("t1_pop_fflags", 32'(fflags), 32'b00001);

        // 2: fill to full, fifth push refused
        drive(1'b1, 16'h4000, 4'b0000);
        step();
        drive(1'b1, 16'h4200, 4'b0000);
        step();
        drive(1'b1, 16'h7C00, 4'b0101);
        step();
        chk("t2_ready_3", 32'(in_ready), 32'd1);
        drive(1'b1, 16'h7E00, 4'b1000);
        step();
        chk("t2_in_ready", 32'(in_ready), 32'd0);
        chk("t2_count", 32'(count), 32'd4);
        chk("t2_fflags", 32'(fflags), 32'b10101);
        drive(1'b1, 16'h3E00, 4'b0010);
        step();
        chk("t2_full_count", 32'(count), 32'd4);
        chk("t2_full_fflags", 32'(fflags), 32'b10101);
        chk("t2_head", 32'(out_result), 32'h4000);

        // 3: full with push+pop -> pop only, then drain in order
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t3_count", 32'(count), 32'd3);
        chk("t3_head", 32'(out_result), 32'h4200);
        chk("t3_head_flags", 32'(out_flags), 32'b00000);
        step();
        chk("t3_d1", 32'(out_result), 32'h7C00);
        chk("t3_d1_flags", 32'(out_flags), 32'b00101);
        step();
        chk("t3_d2", 32'(out_result), 32'h7E00);
        chk("t3_d2_flags", 32'(out_flags), 32'b10000);
        chk("t3_d2_count", 32'(count), 32'd1);
        step();
        chk("t3_empty_valid", 32'(out_valid), 32'd0);
        chk("t3_empty_count", 32'(count), 32'd0);
        step();
        chk("t3_idle_count", 32'(count), 32'd0);

        // 4: streaming with pointer wrap
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16'h1000 + 16'(i), 4'b0000);
            step();
            chk($sformatf("t4_count_%0d", i), 32'(count), 32'd1);
            chk($sformatf("t4_data_%0d", i), 32'(out_result),
                32'h1000 + 32'(i));
        end
        drive(1'b0, 16'h0000, 4'b0000);
        step();
        out_ready = 1'b0;
        chk("t4_end_count", 32'(count), 32'd0);
        chk("t4_end_fflags", 32'(fflags), 32'b10101);

        // 5: clear and same-cycle push
        fflags_clr = 1'b1;
        step();
        fflags_clr = 1'b0;
        chk("t5_clr0", 32'(fflags), 32'd0);
        drive(1'b1, 16'h7E00, 4'b1000);
        step();
        chk("t5_nv", 32'(fflags), 32'b10000);
        drive(1'b1, 16'h0001, 4'b0011);
        fflags_clr = 1'b1;
        step();
        drive(1'b0, 16'h0001, 4'b0011);
        chk("t5_clr_push", 32'(fflags), 32'b00011);
        step();
        fflags_clr = 1'b0;
        chk("t5_clr_only", 32'(fflags), 32'd0);
        chk("t5_count", 32'(count), 32'd2);

        // 6: reset mid-operation drops everything
        drive(1'b1, 16'h7C00, 4'b0101);
        step();
        chk("t6_pre_count", 32'(count), 32'd3);
        chk("t6_pre_fflags", 32'(fflags), 32'b00101);
        drive(1'b1, 16'h5555, 4'b1111);
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(1'b0, 16'h5555, 4'b1111);
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_in_ready", 32'(in_ready), 32'd1);
        chk("t6_fflags", 32'(fflags), 32'd0);
        out_ready = 1'b1;
        step();
        chk("t6_nostore_count", 32'(count), 32'd0);
        chk("t6_nostore_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        drive(1'b1, 16'hC000, 4'b0100);
        step();
        drive(1'b0, 16'hC000, 4'b0000);
        chk("t6_after_head", 32'(out_result), 32'hC000);
        chk("t6_after_flags", 32'(out_flags), 32'b00100);
        chk("t6_after_count", 32'(count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
